rr_right_arbiter: RTL
=====================

// Module: rr_right_arbiter
// PURPOSE
//  Registered round-robin arbiter; scans LSB-first (opposite direction to MSB-first priority arbiter).
//  Accepts N request lines, issues one registered one-hot grant plus binary index, holds it until released.
//  Rotating pointer gives fairness. Sits in front of the shared ALU result bus / shared operand path.
// PARAMETERS
//  N        16  number of request lines (>=2, need not be power of two)
//  MAX_HOLD 8   max grant length in cycles; used only with RR_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  rst        in   1            synchronous, active-high reset
//  req        in   N            request vector, bit i = requester i
//  done       in   1            holder releases grant (sampled only in GRANT)
//  gnt        out  N            registered one-hot grant, 0 when idle
//  gnt_valid  out  1            1 while gnt != 0
//  gnt_idx    out  $clog2(N)    binary index of gnt bit; 0 when idle
//  timeout    out  1            1-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//  Reset: gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE. Reset mid-GRANT: same, next edge.
//  FSM states: IDLE, GRANT.
//  IDLE: if req==0 stay. Else masked = req & ~((1<<ptr)-1); pick = lowest set bit of masked if masked!=0,
//   else lowest set bit of req (wrap). Next edge: gnt=pick, gnt_idx=index(pick), gnt_valid=1, -> GRANT.
//  Latency: req seen at edge t -> gnt visible after edge t+1 (1 cycle). Req changes in same cycle as pick: not an issue, pick uses sampled req.
//  GRANT: grant held stable, req on other lines ignored.
//   Release when done==1 OR req[gnt_idx]==0 at edge: gnt=0, gnt_valid=0, gnt_idx=0,
//   ptr=(gnt_idx==N-1)?0:gnt_idx+1, -> IDLE. One idle cycle always separates consecutive grants.
//  done in IDLE ignored. done and req drop together = single release.
//  ptr width $clog2(N); wrap explicit (no reliance on power-of-two overflow).
//  Invariant: popcount(gnt)<=1; gnt_valid == |gnt.
// CONFIGURATION
//  RR_ARB_TIMEOUT_EN defined: hold_cnt counts cycles in GRANT from 1; if hold_cnt==MAX_HOLD and no release,
//   forced release (same state updates as normal release) and timeout=1 for that one cycle. done on same edge wins: timeout=0.
//  Undefined: no counter, timeout tied 0, grant held indefinitely; MAX_HOLD unused.
// STRUCTURE
//  Package arb_pkg: state enum {IDLE, GRANT}; IDX_W = $clog2(N) helper; one-hot-to-index function.
//  Sub-module right_priority (combinational, N param): out = in & (~in + 1), lowest set bit one-hot.
//   Two instances: masked vector and raw req; top selects by |masked.
//  Top: FSM, ptr register, mask generation, output registers, optional hold counter.
// TESTING
//  1. Reset, req=16'h0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0 every cycle.
//  2. req=16'h0410 after reset -> gnt=16'h0010, idx=4 after 1 cycle; done=1 -> gnt=0 next; then gnt=16'h0400, idx=10.
//  3. Wrap: req=16'h8001 held, done pulsed per grant -> grants bit0, bit15, bit0 (ptr 1->0 wrap).
//  4. req=16'h0020 granted (idx=5), drop req to 0 without done -> gnt=0 next cycle, ptr=6.
//  5. rst=1 while gnt=16'h0100 -> next edge gnt=0, gnt_valid=0; req=16'h0101 -> grant bit0 (ptr reset to 0).
//  6. RR_ARB_TIMEOUT_EN, MAX_HOLD=8, req=16'h0003, no done -> bit0 held 8 cycles, timeout=1 one cycle, then bit1 granted.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg -- shared types and helpers for the round-robin right-scanning arbiter.
//   arb_state_e   : FSM state encoding (IDLE, GRANT)
//   MAX_N         : widest request vector the helpers accept
//   idx_w()       : index width for an N-line arbiter ($clog2(N), min 1)
//   onehot_to_idx : binary index of the (single) set bit of a one-hot vector
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_N = 64;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // OR-reduction of set-bit positions; exact for one-hot or all-zero inputs.
  function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/right_priority.sv
// right_priority -- combinational lowest-set-bit isolator.
//   in  [N-1:0] : arbitrary request vector
//   out [N-1:0] : one-hot vector holding only the lowest set bit of in (0 if in == 0)
module right_priority #(
  parameter int N = 16
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  // Two's complement keeps the lowest set bit and clears everything else.
  assign out = in & (~in + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rr_right_arbiter.sv
// rr_right_arbiter -- registered round-robin arbiter, LSB-first scan from a
// rotating pointer. One grant is issued and held until the holder releases it.
//
// Optional feature macro: RR_ARB_TIMEOUT_EN
//   defined   : a grant is forcibly released after MAX_HOLD cycles, pulsing timeout
//   undefined : no hold counter, grant held indefinitely, timeout stays 0
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   req       in   N      request vector
//   done      in   1      holder releases the grant (only looked at in GRANT)
//   gnt       out  N      registered one-hot grant, 0 when idle
//   gnt_valid out  1      high while gnt != 0
//   gnt_idx   out  IDX_W  binary index of gnt, 0 when idle
//   timeout   out  1      one-cycle pulse on forced release
//
// state | meaning
// IDLE  | no grant outstanding; pick next requester from sampled req
// GRANT | grant held stable; wait for done, request drop or hold limit
module rr_right_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 16,
  parameter int MAX_HOLD = 8,
  localparam int IDX_W   = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_param_check
    $error("rr_right_arbiter: unsupported N or MAX_HOLD");
  end

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             timeout_q, timeout_d;

  logic [N-1:0]     mask;
  logic [N-1:0]     masked_req;
  logic [N-1:0]     pick_masked;
  logic [N-1:0]     pick_raw;
  logic [N-1:0]     pick;
  logic [MAX_N-1:0] pick_ext;
  logic [IDX_W-1:0] pick_idx;
  logic             release_req;
  logic             forced;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD + 1);
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // Lines at or above the pointer are eligible first; explicit compare
  // rather than a shifted mask so non-power-of-two N behaves.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr_q));
    end
  end

  assign masked_req = req & mask;

  right_priority #(.N(N)) u_pri_masked (
    .in  (masked_req),
    .out (pick_masked)
  );

  right_priority #(.N(N)) u_pri_raw (
    .in  (req),
    .out (pick_raw)
  );

  // Nothing at or above the pointer: wrap around to the lowest requester.
  assign pick = (|masked_req) ? pick_masked : pick_raw;

  always_comb begin
    pick_ext        = '0;
    pick_ext[N-1:0] = pick;
  end

  assign pick_idx = IDX_W'(onehot_to_idx(pick_ext));

  // Holder dropping its own request counts as a release.
  assign release_req = done | ~(|(req & gnt_q));

`ifdef RR_ARB_TIMEOUT_EN
  assign forced = (hold_cnt_q == HC_W'(MAX_HOLD));
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = pick;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = HC_W'(1);
`endif
        end
      end
      GRANT: begin
        if (release_req || forced) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
          ptr_d       = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
          state_d     = IDLE;
          // A normal release on the same edge wins over the forced one.
          timeout_d   = forced & ~release_req;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = hold_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      timeout_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      timeout_q   <= timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule
